lcd_bus_sequencer: RTL
======================

# lcd_bus_sequencer

Sequences the character-LCD bus (HD44780-compatible: lcd_RS, lcd_RW, lcd_data, lcd_E) in the nios_system.
- After reset it runs a fixed power-up initialisation sequence.
- It then accepts single-byte command or data writes from a valid/ready requester, typically the CPU-side register bridge.
- For each write it generates the E strobe with programmed setup, pulse-width and hold times, then blocks for the controller execution time.
- The bus is write-only.

## Interface
Parameters:
- T_SETUP, default 3: cycles from RS/data valid to lcd_E rise (≥1).
- T_PW, default 25: cycles lcd_E held high (≥1).
- T_HOLD, default 3: cycles RS/data held after lcd_E fall (≥1).
- T_CMD_WAIT, default 2000: post-write execution wait, normal writes (≥1).
- T_CLEAR_WAIT, default 82000: post-write wait for clear/home commands (≥1).
- T_POWERUP, default 750000: wait after reset before the init sequence (≥1).
- CNT_W, default 20: delay counter width. Must hold the largest T_* minus 1.

Ports:
- clk_clk, in, 1: system clock.
- reset_reset_n, in, 1: asynchronous reset, active low.
- cmd_valid, in, 1: write request.
- cmd_ready, out, 1: block can accept a write. The transfer occurs when cmd_valid & cmd_ready at a rising edge.
- cmd_rs, in, 1: 0 = instruction, 1 = display data.
- cmd_data, in, 8: byte to write.
- busy, out, 1: equals ~cmd_ready.
- init_done, out, 1: init sequence complete; sticky until reset.
- lcd_RS, out, 1: register select.
- lcd_RW, out, 1: constant 0 (write only).
- lcd_data_out, out, 8: bus data. The top level drives the inout lcd_data with it when lcd_data_oe = 1.
- lcd_data_oe, out, 1: data bus output enable.
- lcd_E, out, 1: enable strobe.

## Operation
- FSM states:
  - PWRUP, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, WAIT.
  - A down-counter, CNT_W bits, times each state.
  - A 2-bit init index and a captured {rs, data} register are also kept.
- PWRUP: wait T_POWERUP cycles, then INIT_LOAD.
- INIT_LOAD: load the init ROM entry for the current index into the capture register (rs = 0), then enter SETUP. ROM:
  - index 0: 0x38
  - index 1: 0x0C
  - index 2: 0x01
  - index 3: 0x06
- IDLE: cmd_ready = 1. On handshake, capture {cmd_rs, cmd_data} and enter SETUP. cmd_data is ignored when no handshake occurs.
- SETUP: T_SETUP cycles, then PULSE (lcd_E = 1 for T_PW cycles), then HOLD (T_HOLD cycles), then WAIT.
- WAIT length:
  - T_CLEAR_WAIT if rs = 0 and data[7:1] == 7'b0000000 with data[0] != 0 or data == 0x02/0x03, i.e. data ∈ {0x01, 0x02, 0x03}.
  - Otherwise T_CMD_WAIT.
- WAIT exit:
  - During init, go to INIT_LOAD with index+1. After index 3, set init_done and go to IDLE.
  - Otherwise go to IDLE.
- Output drive:
  - lcd_RS and lcd_data_out reflect the capture register from SETUP through HOLD.
  - lcd_data_oe = 1 only in SETUP, PULSE and HOLD.
  - All outputs are registered and glitch-free.
- Illegal or unreachable states recover to PWRUP.

## Timing
- Reset values (asynchronous, immediate):
  - cmd_ready = 0, busy = 1, init_done = 0.
  - lcd_E = 0, lcd_RS = 0, lcd_RW = 0.
  - lcd_data_out = 0x00, lcd_data_oe = 0.
  - State = PWRUP, counter loaded with T_POWERUP-1.
- Reset mid-transfer: lcd_E drops in the same instant and the full init sequence reruns. No partial recovery.
- Cycle 0 is the first rising edge with reset_reset_n high.
- INIT_LOAD costs 1 cycle per init entry.
- Per write, with handshake at edge N:
  - lcd_RS, lcd_data_out and lcd_data_oe are valid after edge N+1.
  - lcd_E rises after edge N+1+T_SETUP and falls after edge N+1+T_SETUP+T_PW.
  - lcd_data_oe falls after edge N+1+T_SETUP+T_PW+T_HOLD.
  - cmd_ready returns after edge N+1+T_SETUP+T_PW+T_HOLD+wait.
- cmd_ready never asserts before init_done = 1.
- cmd_valid held during busy is ignored, not queued. The requester holds the request until cmd_ready.
- Back-to-back: a handshake on the first cycle cmd_ready is high starts the next write immediately. No extra idle cycle is required.

## Test plan
Bench parameters: T_SETUP=2, T_PW=4, T_HOLD=2, T_CMD_WAIT=10, T_CLEAR_WAIT=30, T_POWERUP=20, CNT_W=8.

- Release reset, no requests:
  - Exactly 4 lcd_E pulses occur, each 4 cycles wide, with lcd_data_out 0x38, 0x0C, 0x01, 0x06 and lcd_RS = 0.
  - Gap after 0x01 is 30+ cycles; the others are 10+.
  - init_done = 1 and cmd_ready = 1 at cycle 20 + 4×1 + 3×18 + 38 = 116.
- After init, write rs=1, data=0x41:
  - lcd_RS = 1 and lcd_data_out = 0x41 for SETUP+PULSE+HOLD.
  - Exactly one lcd_E pulse, 2 cycles after data valid, 4 cycles wide.
  - lcd_data_oe is high for 8 cycles.
  - cmd_ready returns 19 cycles after the handshake.
- Write rs=0, data=0x01 versus rs=0, data=0x80:
  - cmd_ready returns 39 versus 19 cycles after the handshake.
- Hold cmd_valid high with 3 queued values:
  - Each handshake occurs on the first cycle cmd_ready = 1.
  - No lcd_E pulse is lost or duplicated, and lcd_RW stays 0 throughout.
- Assert reset_reset_n low for 1 cycle while lcd_E = 1:
  - lcd_E and lcd_data_oe go low without waiting for a clock edge.
  - init_done = 0.
  - The full init sequence repeats, again completing at cycle 116.
- Pulse cmd_valid during init and during WAIT:
  - No handshake occurs, cmd_ready stays 0, and no extra lcd_E pulse appears.

Source files
------------

// File: rtl/lcd_bus_sequencer.sv
// lcd_bus_sequencer: drives a write-only HD44780-style character LCD bus.
// It runs the power-up init sequence and then serves single-byte writes from
// a valid/ready requester. Each write gets the E strobe with programmed
// setup, pulse and hold times, followed by the controller execution wait.
// All bus outputs come from flops that are fed by the current state, so they
// trail the state register by one cycle.
module lcd_bus_sequencer #(
  parameter int T_SETUP      = 3,
  parameter int T_PW         = 25,
  parameter int T_HOLD       = 3,
  parameter int T_CMD_WAIT   = 2000,
  parameter int T_CLEAR_WAIT = 82000,
  parameter int T_POWERUP    = 750000,
  parameter int CNT_W        = 20
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_RS,
  output logic       lcd_RW,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  output logic       lcd_E
);

  typedef enum logic [2:0] {
    ST_PWRUP     = 3'd0,
    ST_INIT_LOAD = 3'd1,
    ST_IDLE      = 3'd2,
    ST_SETUP     = 3'd3,
    ST_PULSE     = 3'd4,
    ST_HOLD      = 3'd5,
    ST_WAIT      = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PW      = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_CMD     = CNT_W'(T_CMD_WAIT - 1);
  localparam logic [CNT_W-1:0] LD_CLEAR   = CNT_W'(T_CLEAR_WAIT - 1);
  localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(T_POWERUP - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             cap_rs_q, cap_rs_d;
  logic [7:0]       cap_data_q, cap_data_d;
  logic             ready_q, ready_d;
  logic             init_done_q, init_done_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             oe_q, oe_d;
  logic             e_q, e_d;

  logic       handshake;
  logic       cnt_zero;
  logic       is_clear;
  logic       drive_bus;
  logic [7:0] rom_byte;

  // Init ROM lookup and the small decodes shared by the FSM and output logic
  always_comb begin
    rom_byte = 8'h38;
    case (idx_q)
      2'd0: rom_byte = 8'h38;
      2'd1: rom_byte = 8'h0C;
      2'd2: rom_byte = 8'h01;
      2'd3: rom_byte = 8'h06;
      default: rom_byte = 8'h38;
    endcase
    handshake = cmd_valid && ready_q && (state_q == ST_IDLE);
    cnt_zero  = (cnt_q == '0);
    is_clear  = !cap_rs_q && ((cap_data_q == 8'h01) || (cap_data_q == 8'h02) ||
                              (cap_data_q == 8'h03));
    drive_bus = (state_q == ST_SETUP) || (state_q == ST_PULSE) || (state_q == ST_HOLD);
  end

  // Next-state logic: every timed state counts down to zero, then reloads for the next one
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    cap_rs_d   = cap_rs_q;
    cap_data_d = cap_data_q;
    case (state_q)
      ST_PWRUP: begin
        if (cnt_zero) state_d = ST_INIT_LOAD;
        else          cnt_d   = cnt_q - 1'b1;
      end
      ST_INIT_LOAD: begin
        cap_rs_d   = 1'b0;
        cap_data_d = rom_byte;
        cnt_d      = LD_SETUP;
        state_d    = ST_SETUP;
      end
      ST_IDLE: begin
        if (handshake) begin
          cap_rs_d   = cmd_rs;
          cap_data_d = cmd_data;
          cnt_d      = LD_SETUP;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_d   = LD_PW;
          state_d = ST_PULSE;
        end else cnt_d = cnt_q - 1'b1;
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          cnt_d   = LD_HOLD;
          state_d = ST_HOLD;
        end else cnt_d = cnt_q - 1'b1;
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          cnt_d   = is_clear ? LD_CLEAR : LD_CMD;
          state_d = ST_WAIT;
        end else cnt_d = cnt_q - 1'b1;
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          // init_done only rises after the first IDLE cycle, so it also marks init mode
          if (!init_done_q && (idx_q != 2'd3)) begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_INIT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else cnt_d = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_PWRUP;
        cnt_d   = LD_POWERUP;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Output flop inputs; ready also drops on the handshake edge so no second transfer is offered
  always_comb begin
    ready_d     = (state_q == ST_IDLE) && (state_d == ST_IDLE);
    init_done_d = init_done_q || (state_q == ST_IDLE);
    rs_d        = drive_bus && cap_rs_q;
    data_d      = drive_bus ? cap_data_q : 8'h00;
    oe_d        = drive_bus;
    e_d         = (state_q == ST_PULSE);
  end

  // State, counter, capture and output registers with asynchronous active-low reset
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_PWRUP;
      cnt_q       <= LD_POWERUP;
      idx_q       <= 2'd0;
      cap_rs_q    <= 1'b0;
      cap_data_q  <= 8'h00;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      oe_q        <= 1'b0;
      e_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      cap_rs_q    <= cap_rs_d;
      cap_data_q  <= cap_data_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      oe_q        <= oe_d;
      e_q         <= e_d;
    end
  end

  assign cmd_ready    = ready_q;
  assign busy         = ~ready_q;
  assign init_done    = init_done_q;
  assign lcd_RS       = rs_q;
  assign lcd_RW       = 1'b0;
  assign lcd_data_out = data_q;
  assign lcd_data_oe  = oe_q;
  assign lcd_E        = e_q;

endmodule
